// File: rtl/instr_encoder_if.sv
// instr_encoder_if: descriptor handshake and instruction-memory write bus for instr_encoder.
interface instr_encoder_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [4:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [25:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    modport master (
        output in_valid, in_last, op, rs, rt, rd, shamt, imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  in_valid, in_last, op, rs, rt, rd, shamt, imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes op descriptors to MIPS words, buffers them and streams them into instruction memory.
// Optional ENC_RANGE_CHECK_EN drops I-types with out-of-range imm and non-shift R-types with shamt != 0.
module instr_encoder #(
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                MEM_WORDS  = 256,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    instr_encoder_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] words_written
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MEM_WORDS + 1);
    localparam logic [CW-1:0] MAXW = CW'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t            r_state;
    logic [31:0]       r_fifo [FIFO_DEPTH];
    logic [AW:0]       r_wp, r_rp;
    logic [ADDR_W-1:0] r_addr, r_cnt;
    logic [CW-1:0]     r_acc;
    logic              r_err;
    logic [31:0]       w_enc;
    logic [25:0]       w_it;
    logic [19:0]       w_rf;
    logic              w_ok, w_rng, w_legal, w_empty, w_full, w_acc, w_push, w_pop;

    assign w_it  = {bus.rs, bus.rt, bus.imm[15:0]};
    assign w_rf  = {bus.rs, bus.rt, bus.rd, bus.shamt};

    always_comb begin
        w_enc = '0;
        w_ok  = 1'b1;
        case (bus.op)
            5'd0:    w_enc = {6'b0, w_rf, 6'b100000};
            5'd1:    w_enc = {6'b0, w_rf, 6'b100100};
            5'd2:    w_enc = {6'b0, w_rf, 6'b100101};
            5'd3:    w_enc = {11'b0, bus.rt, bus.rd, bus.shamt, 6'b000000};
            5'd4:    w_enc = {6'b0, w_rf, 6'b101010};
            5'd5:    w_enc = {11'b0, bus.rt, bus.rd, bus.shamt, 6'b000010};
            5'd6:    w_enc = {6'b0, w_rf, 6'b100010};
            5'd7:    w_enc = {6'b0, w_rf, 6'b100110};
            5'd8:    w_enc = {6'b0, bus.rs, 15'b0, 6'b001000};
            5'd9:    w_enc = '0;
            5'd10:   w_enc = {6'b001000, w_it};
            5'd11:   w_enc = {6'b001100, w_it};
            5'd12:   w_enc = {6'b001101, w_it};
            5'd13:   w_enc = {6'b001110, w_it};
            5'd14:   w_enc = {6'b001010, w_it};
            5'd15:   w_enc = {6'b000100, w_it};
            5'd16:   w_enc = {6'b000101, w_it};
            5'd17:   w_enc = {6'b100000, w_it};
            5'd18:   w_enc = {6'b100011, w_it};
            5'd19:   w_enc = {6'b101000, w_it};
            5'd20:   w_enc = {6'b101011, w_it};
            5'd21:   w_enc = {6'b000010, bus.imm};
            5'd22:   w_enc = {6'b000011, bus.imm};
            default: w_ok  = 1'b0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    assign w_rng = (bus.op >= 5'd10 && bus.op <= 5'd20 && bus.imm[25:16] != {10{bus.imm[15]}}) ||
                   (bus.op inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd6, 5'd7} && bus.shamt != 5'd0);
`else
    assign w_rng = 1'b0;
`endif

    assign w_legal       = w_ok && !w_rng;
    assign w_empty       = r_wp == r_rp;
    assign w_full        = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
    assign busy          = r_state == LOAD || r_state == FLUSH;
    assign done          = r_state == DONE;
    assign err           = r_err;
    assign words_written = r_cnt;
    assign bus.in_ready  = r_state == LOAD && !w_full && r_acc != MAXW;
    assign bus.mem_we    = !w_empty && busy;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_empty ? '0 : r_fifo[r_rp[AW-1:0]];
    assign w_acc         = bus.in_valid && bus.in_ready;
    assign w_push        = w_acc && w_legal;
    assign w_pop         = bus.mem_we && bus.mem_ready;

    always_ff @(posedge clk)
        if (w_push) r_fifo[r_wp[AW-1:0]] <= w_enc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_addr  <= BASE_ADDR;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) begin
                r_rp   <= r_rp + 1'b1;
                r_addr <= r_addr + ADDR_W'(4);
                r_cnt  <= r_cnt + 1'b1;
            end
            case (r_state)
                IDLE, DONE: if (start) begin
                    r_state <= LOAD;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_acc   <= '0;
                    r_addr  <= BASE_ADDR;
                end
                LOAD: if (w_acc) begin
                    if (w_legal) r_acc <= r_acc + 1'b1;
                    else r_err <= 1'b1;
                    // Filling the session without in_last is an overflow.
                    if (bus.in_last) r_state <= FLUSH;
                    else if (w_legal && r_acc + 1'b1 == MAXW) begin
                        r_state <= FLUSH;
                        r_err   <= 1'b1;
                    end
                end
                FLUSH: if (w_empty) r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential instruction encoder and program loader: the inverse of the control decoder. Accepts symbolic operation descriptors over a valid/ready handshake, encodes them into 32-bit MIPS words, buffers them in a FIFO, and writes them sequentially into instruction memory through a write port with backpressure. Used by the test and boot infrastructure to fill instruction memory before the core runs.

Parameters:
ADDR_W, 10, instruction memory byte-address width
BASE_ADDR, 0, byte address of the first written word (word aligned)
MEM_WORDS, 256, maximum words accepted per load session
FIFO_DEPTH, 4, encoded-word FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a load session
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid && in_ready
in_last  in  1  descriptor is the final one of the session
op  in  5  0 ADD, 1 AND, 2 OR, 3 SLL, 4 SLT, 5 SRL, 6 SUB, 7 XOR, 8 JR, 9 NOP, 10 ADDI, 11 ANDI, 12 ORI, 13 XORI, 14 SLTI, 15 BEQ, 16 BNE, 17 LB, 18 LW, 19 SB, 20 SW, 21 J, 22 JAL; 23-31 illegal
rs, rt, rd, shamt  in  5 each  register fields and shift amount
imm  in  26  immediate in [15:0] for I-type, jump target for J/JAL
mem_we  out  1  write request
mem_addr  out  ADDR_W  byte address of the write
mem_wdata  out  32  encoded instruction
mem_ready  in  1  memory accepts write when mem_we && mem_ready
busy  out  1  session active
done  out  1  level, session complete
err  out  1  sticky: illegal op, overflow, or range violation
words_written  out  ADDR_W  words committed this session

Behaviour:
- Reset (async, reset_n low): state IDLE; FIFO empty; address = BASE_ADDR; in_ready, mem_we, busy, done, err = 0; words_written = 0; mem_wdata = 0. Reset mid-session abandons all buffered words.
- FSM: IDLE -> LOAD on start (clears done, err, words_written, accepted count; address = BASE_ADDR). LOAD -> FLUSH when a descriptor with in_last is accepted, or when accepted count reaches MEM_WORDS. FLUSH -> DONE when the FIFO is empty and no write is pending. DONE -> LOAD on start. start is ignored in LOAD/FLUSH.
- busy = state in {LOAD, FLUSH}. done = state DONE.
- in_ready = LOAD && FIFO not full && accepted < MEM_WORDS.
- Encoding (combinational from inputs, pushed to FIFO on the accepting edge):
  R-type {6'b0, rs, rt, rd, shamt, funct}; funct ADD 100000, AND 100100, OR 100101, SLT 101010, SUB 100010, XOR 100110.
  SLL/SRL: rs forced 0, funct 000000/000010.
  JR: {6'b0, rs, 15'b0, 001000}. NOP: 32'h0.
  I-type {opc, rs, rt, imm[15:0]}; opc ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, BEQ 000100, BNE 000101, LB 100000, LW 100011, SB 101000, SW 101011.
  J/JAL {000010/000011, imm[25:0]}.
  Fields not used by an op are ignored.
- Illegal op: the handshake completes, nothing is pushed, err is set, and the descriptor does not count toward accepted. in_last on an illegal op still moves the FSM to FLUSH.
- Write side: mem_we = FIFO non-empty && state in {LOAD, FLUSH}; mem_wdata = FIFO head; mem_addr = current address. On mem_we && mem_ready: pop, address += 4, words_written += 1. mem_addr/mem_wdata stay stable while mem_we && !mem_ready.
- Latency: a descriptor accepted at edge N appears on mem_we/mem_wdata in cycle N+1 when the FIFO was empty. Throughput is 1 word/cycle with mem_ready high.
- Simultaneous push and pop on a full FIFO is not possible (in_ready = 0). Push and pop on a non-full FIFO in the same cycle both occur.
- Overflow: when accepted reaches MEM_WORDS without in_last, the FSM enters FLUSH and sets err.
- Address wraps modulo 2^ADDR_W.

Optional Feature:
ENC_RANGE_CHECK_EN: when defined, an I-type descriptor whose imm[25:16] is not all copies of imm[15], or a non-shift R-type with shamt != 0, is treated like an illegal op (dropped, err set). When undefined, imm is silently truncated to [15:0] and shamt is encoded as given.

Test Plan:
- start; ADD rs=1 rt=2 rd=3, in_last; mem_ready=1 -> one write addr 0x000 data 0x00221820 in the cycle after acceptance; done=1, words_written=1, err=0.
- Sequence ADDI(1,2,5), SLL(rt=2,rd=3,shamt=4), LW(rs=29,rt=8,4), BEQ(1,2,0xFFFF), J(0x100) with last -> data 0x20220005, 0x00021900, 0x8FA80004, 0x1022FFFF, 0x08000100 at addr 0x0,0x4,0x8,0xC,0x10.
- mem_ready held 0 for 10 cycles during a 6-descriptor burst -> in_ready drops after 4 accepted; mem_addr/mem_wdata stable; all 6 words written in order once mem_ready=1.
- op=25 mid-stream between two ADDs -> err=1, only 2 words written, addresses contiguous.
- MEM_WORDS=4, 6 descriptors without in_last -> 4 written, in_ready stays 0, done=1, err=1.
- reset_n low during FLUSH with 3 buffered words -> mem_we=0 immediately; FSM IDLE; subsequent start writes from BASE_ADDR. With ENC_RANGE_CHECK_EN: ADDI imm=0x10000 -> dropped, err=1.
